// File: rtl/unpacked_stream_arbiter_pkg.sv
// Shared types and helpers for the unpacked stream arbiter.
// Holds the control-state enum and the source-index width function.
// Imported by the arbiter top and its round-robin picker.
package unpacked_stream_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a source index; one bit minimum so a single-source build still
  // has a legal vector.
  function automatic int calc_src_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/unpacked_stream_arbiter_rr_grant.sv
// Round-robin priority picker: first request at or after ptr_i, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of req_i and ptr_i.
// Ports: req_i (per-source request), ptr_i (search start),
//        gnt_o (one-hot grant, zero if no request), idx_o (grant index).
module unpacked_stream_arbiter_rr_grant
  import unpacked_stream_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = calc_src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SRC_W-1:0]   idx_o
);

  int               cand;
  logic [SRC_W-1:0] cand_idx;

  // Walk from the furthest offset back towards ptr_i so the request closest
  // to ptr_i is the last assignment and therefore wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand     = (int'(ptr_i) + k) % NUM_SRC;
      cand_idx = SRC_W'(cand);
      if (req_i[cand_idx]) begin
        gnt_o           = '0;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/unpacked_stream_arbiter.sv
// Packet-aware round-robin merge of NUM_SRC unpacked vector streams.
// Latency: 1 cycle from input accept to registered data_out.
// Backpressure: data_in_ready only when the output register is empty or draining.
// Ports: clk/rst (async active-high); data_in/_valid/_last/_ready per source;
//        data_out/_valid/_last/_src registered output, data_out_ready from downstream.
module unpacked_stream_arbiter
  import unpacked_stream_arbiter_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int IN_NUM     = 8,
  localparam int SRC_W      = calc_src_w(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [NUM_SRC][IN_NUM],
  input  logic [NUM_SRC-1:0]    data_in_valid,
  input  logic [NUM_SRC-1:0]    data_in_last,
  output logic [NUM_SRC-1:0]    data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [IN_NUM],
  output logic                  data_out_valid,
  output logic                  data_out_last,
  output logic [SRC_W-1:0]      data_out_src,
  input  logic                  data_out_ready
);

  arb_state_e            state_q, state_d;
  logic [SRC_W-1:0]      lock_src_q, lock_src_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0]    rr_gnt;
  logic [SRC_W-1:0]      rr_idx;
  logic [NUM_SRC-1:0]    grant;
  logic [SRC_W-1:0]      sel;
  logic [SRC_W-1:0]      sel_inc;
  logic                  can_load;
  logic                  accept;

  logic [DATA_WIDTH-1:0] dout_q [IN_NUM];
  logic                  vld_q;
  logic                  last_q;
  logic [SRC_W-1:0]      src_q;

  unpacked_stream_arbiter_rr_grant #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_grant (
    .req_i (data_in_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // While locked, the owner keeps the grant even with valid low, so a stalled
  // packet blocks everyone else until its last beat arrives.
  assign sel      = (state_q == LOCKED) ? lock_src_q : rr_idx;
  assign grant    = (state_q == LOCKED) ? (NUM_SRC'(1) << lock_src_q) : rr_gnt;
  assign can_load = !vld_q || data_out_ready;
  // rst gating matters because the IDLE grant is combinational on valid.
  assign data_in_ready = rst ? '0 : (grant & {NUM_SRC{can_load}});
  assign accept        = |(data_in_valid & data_in_ready);
  assign sel_inc       = (int'(sel) == NUM_SRC - 1) ? '0 : sel + SRC_W'(1);

  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      if (data_in_last[sel]) begin
        state_d  = IDLE;
        rr_ptr_d = sel_inc;
      end else begin
        state_d    = LOCKED;
        lock_src_d = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_src_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      src_q  <= '0;
      for (int i = 0; i < IN_NUM; i++) dout_q[i] <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      last_q <= data_in_last[sel];
      src_q  <= sel;
      for (int i = 0; i < IN_NUM; i++) dout_q[i] <= data_in[sel][i];
    end else if (can_load) begin
      vld_q <= 1'b0;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = vld_q;
  assign data_out_last  = last_q;
  assign data_out_src   = src_q;

endmodule
